// File: rtl/clb_config_loader_pkg.sv
// Shared constants and FSM state type for the CLB configuration loader.
// A LUT segment packs the truth table, the interconnect selects and the mux switch bit.
package clb_config_pkg;

  localparam int LUT_TT_W   = 16;
  localparam int IC_SEL_W   = 5;
  localparam int IC_PER_LUT = 4;
  localparam int MUX_SW_W   = 1;

  localparam int LUT_BITS = LUT_TT_W + IC_PER_LUT * IC_SEL_W + MUX_SW_W;
  localparam int NUM_LUTS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } cfg_state_e;

endpackage

// File: rtl/clb_config_loader_if.sv
// Host word handshake between the configuration source and the loader.
interface clb_config_loader_if #(
  parameter int WORD_W = 8
);

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/clb_config_loader_piso.sv
// Parallel-in/serial-out word buffer: presents the current bit on bit_o, LSB first,
// and tracks whether any unsent bits remain.
module clb_cfg_piso #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [WORD_W-1:0] word,
  output logic              bit_o,
  output logic              last,
  output logic              empty
);

  localparam int WBIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [WBIT_W-1:0] WBIT_LAST = WBIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sreg;
  logic [WBIT_W-1:0] wbit;
  logic              full;

  // Load wins over shift so a prefetched word replaces the final bit with no bubble;
  // shifting the final bit without a reload keeps it on bit_o during a stall.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sreg <= '0;
      wbit <= '0;
      full <= 1'b0;
    end else if (clear) begin
      sreg <= '0;
      wbit <= '0;
      full <= 1'b0;
    end else if (load) begin
      sreg <= word;
      wbit <= '0;
      full <= 1'b1;
    end else if (shift) begin
      if (wbit == WBIT_LAST) begin
        full <= 1'b0;
      end else begin
        sreg <= sreg >> 1;
        wbit <= wbit + 1'b1;
      end
    end
  end

  assign bit_o = sreg[0];
  assign last  = (wbit == WBIT_LAST);
  assign empty = !full;

endmodule

// File: rtl/clb_config_loader.sv
// Transmit end of the CLB configuration chain: serialises host words into
// NUM_LUTS segments of LUT_BITS bits, with one separator cycle between segments.
module clb_config_loader #(
  parameter int LUT_BITS = clb_config_pkg::LUT_BITS,
  parameter int NUM_LUTS = clb_config_pkg::NUM_LUTS,
  parameter int WORD_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       start,
  clb_config_loader_if.slave         host,
  output logic                       bit_out,
  output logic                       cfg_en,
  output logic                       prgm_b,
  output logic                       CLB_prgm_b,
  output logic                       busy,
  output logic                       done
);

  import clb_config_pkg::*;

  localparam int TOTAL_BITS = LUT_BITS * NUM_LUTS;
  localparam int LBIT_W     = (LUT_BITS > 1) ? $clog2(LUT_BITS) : 1;
  localparam int LUT_W      = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam int CNT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;

  localparam logic [LBIT_W-1:0] LBIT_LAST  = LBIT_W'(LUT_BITS - 1);
  localparam logic [LUT_W-1:0]  LUT_LAST   = LUT_W'(NUM_LUTS - 1);
  localparam logic [CNT_W-1:0]  TOTAL_LAST = CNT_W'(TOTAL_BITS - 1);

  cfg_state_e        state;
  logic [LBIT_W-1:0] lbit;
  logic [LUT_W-1:0]  lut;
  logic [CNT_W-1:0]  bit_cnt;

  logic seg_end;
  logic final_bit;
  logic word_ready;
  logic xfer;
  logic piso_bit;
  logic piso_last;
  logic piso_empty;

  assign seg_end   = (lbit == LBIT_LAST);
  assign final_bit = (bit_cnt == TOTAL_LAST);

  // Prefetch the next word while its predecessor's last bit is on the wire.
  assign word_ready = (state == LOAD) ||
                      ((state == SHIFT) && piso_last && !final_bit);
  assign xfer       = host.word_valid && word_ready;

  assign host.word_ready = word_ready;
  assign bit_out         = piso_bit;

  clb_cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk     (clk),
    .reset_b (reset_b),
    .load    (xfer),
    .shift   (state == SHIFT),
    .clear   ((state == SHIFT) && final_bit),
    .word    (host.word_in),
    .bit_o   (piso_bit),
    .last    (piso_last),
    .empty   (piso_empty)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      lbit       <= '0;
      lut        <= '0;
      bit_cnt    <= '0;
      cfg_en     <= 1'b0;
      prgm_b     <= 1'b1;
      CLB_prgm_b <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            prgm_b     <= 1'b0;
            CLB_prgm_b <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            state  <= SHIFT;
            cfg_en <= 1'b1;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (final_bit) begin
            state      <= DONE;
            cfg_en     <= 1'b0;
            prgm_b     <= 1'b1;
            CLB_prgm_b <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            lbit       <= '0;
            lut        <= '0;
            bit_cnt    <= '0;
          end else if (seg_end && (lut != LUT_LAST)) begin
            // Word exhaustion on this bit is resolved in GAP via piso_empty.
            state  <= GAP;
            cfg_en <= 1'b0;
            lbit   <= '0;
            lut    <= lut + 1'b1;
          end else begin
            lbit <= lbit + 1'b1;
            if (piso_last && !xfer) begin
              state  <= LOAD;
              cfg_en <= 1'b0;
            end
          end
        end
        GAP: begin
          if (piso_empty) begin
            state <= LOAD;
          end else begin
            state  <= SHIFT;
            cfg_en <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader: table of sessions plus randomized sessions checked
// against an arithmetic bit-stream and timing model, and a mid-session reset sequence.
module tb_clb_config_loader;

  localparam int WORD_W   = 8;
  localparam int LUT_BITS = 37;
  localparam int NUM_LUTS = 3;
  localparam int NBITS    = LUT_BITS * NUM_LUTS;
  localparam int NWORDS   = (NBITS + WORD_W - 1) / WORD_W;
  localparam int MAXC     = 512;

  typedef struct {
    string tag;
    int    pat;
    int    sw;
    int    sl;
    int    restart;
    int    exp_done;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_b = 1'b0;
  logic start   = 1'b0;
  logic bit_out, cfg_en, prgm_b, CLB_prgm_b, busy, done;

  clb_config_loader_if #(.WORD_W(WORD_W)) host_if ();

  clb_config_loader #(
    .LUT_BITS (LUT_BITS),
    .NUM_LUTS (NUM_LUTS),
    .WORD_W   (WORD_W)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .start      (start),
    .host       (host_if),
    .bit_out    (bit_out),
    .cfg_en     (cfg_en),
    .prgm_b     (prgm_b),
    .CLB_prgm_b (CLB_prgm_b),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  logic [WORD_W-1:0] wq [NWORDS];
  logic              exp_bits [NBITS];
  logic              host_stop = 1'b0;

  // Per-session observation, indexed by cycle relative to the start pulse.
  logic mon_on = 1'b0;
  int   t0 = 0;
  logic cfg_a [MAXC];
  logic bit_a [MAXC];
  logic prgm_a [MAXC];
  logic clb_a [MAXC];
  logic busy_a [MAXC];
  logic cap [$];
  int   capc [$];
  int   done_cyc = -1;
  int   done_cnt = 0;
  int   xfer_cnt = 0;
  int   rdy_after = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      int rel;
      rel = edges - t0;
      if (rel == 0) begin
        cap.delete();
        capc.delete();
        done_cyc  = -1;
        done_cnt  = 0;
        xfer_cnt  = 0;
        rdy_after = 0;
      end
      if (rel >= 0 && rel < MAXC) begin
        cfg_a[rel]  = cfg_en;
        bit_a[rel]  = bit_out;
        prgm_a[rel] = prgm_b;
        clb_a[rel]  = CLB_prgm_b;
        busy_a[rel] = busy;
      end
      if (cfg_en) begin
        cap.push_back(bit_out);
        capc.push_back(rel);
      end
      if (done_cnt > 0 && !done && host_if.word_ready) rdy_after++;
      if (done) begin
        if (done_cnt == 0) done_cyc = rel;
        done_cnt++;
      end
      if (host_if.word_valid && host_if.word_ready) xfer_cnt++;
    end
  end

  task automatic check(input string tag, input string what, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  // Reference timing: one bit per cycle from cycle 2, one separator cycle per
  // completed segment, plus the host stall once the stalled word is reached.
  function automatic int exp_cyc(input int i, input int sw, input int sl);
    return 2 + i + i / LUT_BITS + ((sl > 0 && i >= WORD_W * sw) ? sl : 0);
  endfunction

  task automatic make_words(input int pat);
    int mk [6] = '{0, 36, 37, 73, 74, 110};
    for (int w = 0; w < NWORDS; w++) begin
      case (pat)
        2:       wq[w] = WORD_W'($urandom);
        3:       wq[w] = 8'hA5;
        default: wq[w] = '0;
      endcase
    end
    if (pat < 2) foreach (mk[j]) wq[mk[j] / WORD_W][mk[j] % WORD_W] = 1'b1;
    if (pat == 1) wq[NWORDS-1][WORD_W-1] = 1'b1;
    for (int i = 0; i < NBITS; i++) exp_bits[i] = wq[i / WORD_W][i % WORD_W];
  endtask

  // Host: offers words in order; word sw is withheld until word_ready has been
  // seen high sl times while it is pending.
  task automatic host_loop(input int sw, input int sl);
    int   idx = 0;
    int   stall_left = sl;
    logic took;
    host_if.word_in    = wq[0];
    host_if.word_valid = 1'b1;
    while (!host_stop) begin
      @(negedge clk);
      took = host_if.word_valid && host_if.word_ready;
      if (idx == sw && stall_left > 0 && host_if.word_ready) stall_left--;
      @(posedge clk);
      #1;
      if (took) idx++;
      host_if.word_in    = (idx < NWORDS) ? wq[idx] : '0;
      host_if.word_valid = (idx < NWORDS) && !(idx == sw && stall_left > 0);
    end
    host_if.word_valid = 1'b0;
  endtask

  task automatic run_session(input string tag, input int pat, input int sw, input int sl,
                             input int restart, input int exp_done);
    int model_done;
    int sm;
    int cm;
    make_words(pat);
    host_stop = 1'b0;
    @(posedge clk);
    #1;
    t0     = edges;
    start  = 1'b1;
    mon_on = 1'b1;
    fork
      host_loop(sw, sl);
      begin
        int post = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (post < 6 && (edges - t0) < 400) begin
          @(posedge clk);
          #1;
          start = ((edges - t0) == restart);
          if (done_cnt > 0) post++;
        end
        start     = 1'b0;
        host_stop = 1'b1;
      end
    join
    mon_on = 1'b0;

    model_done = exp_cyc(NBITS - 1, sw, sl) + 1;
    check(tag, "prgm_b_c0", int'(prgm_a[0]), 1);
    check(tag, "prgm_b_c1", int'(prgm_a[1]), 0);
    check(tag, "clb_prgm_b_c1", int'(clb_a[1]), 1);
    check(tag, "busy_c1", int'(busy_a[1]), 1);
    check(tag, "cfg_en_c1", int'(cfg_a[1]), 0);
    check(tag, "nbits", cap.size(), NBITS);
    sm = 0;
    cm = 0;
    for (int i = 0; i < NBITS && i < cap.size(); i++) begin
      if (cap[i] !== exp_bits[i]) sm++;
      if (capc[i] != exp_cyc(i, sw, sl)) cm++;
    end
    check(tag, "stream_errs", sm, 0);
    check(tag, "timing_errs", cm, 0);
    check(tag, "done_cyc", done_cyc, (exp_done < 0) ? model_done : exp_done);
    check(tag, "done_cnt", done_cnt, 1);
    check(tag, "words", xfer_cnt, NWORDS);
    check(tag, "ready_after_done", rdy_after, 0);
    if (done_cyc >= 0 && done_cyc < MAXC) begin
      check(tag, "prgm_b_done", int'(prgm_a[done_cyc]), 1);
      check(tag, "clb_prgm_b_done", int'(clb_a[done_cyc]), 0);
      check(tag, "busy_done", int'(busy_a[done_cyc]), 0);
      check(tag, "cfg_en_done", int'(cfg_a[done_cyc]), 0);
    end
    if (pat < 2 && cap.size() >= NBITS) begin
      check(tag, "seg0_first", int'(cap[0]), 1);
      check(tag, "seg0_last", int'(cap[36]), 1);
      check(tag, "seg1_first", int'(cap[37]), 1);
      check(tag, "seg2_last", int'(cap[110]), 1);
      check(tag, "gap_seg0_seg1", capc[37] - capc[36], 2);
      check(tag, "gap_seg1_seg2", capc[74] - capc[73], 2);
    end
    if (sl > 0) begin
      int s0 = exp_cyc(WORD_W * sw - 1, sw, sl);
      int errs = 0;
      for (int c = s0 + 1; c <= s0 + sl; c++) begin
        if (cfg_a[c] !== 1'b0 || bit_a[c] !== exp_bits[WORD_W * sw - 1]) errs++;
      end
      check(tag, "stall_hold", errs, 0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    tbl[0] = '{"base",      0, 0, 0, 0,  115};
    tbl[1] = '{"tail_bit",  1, 0, 0, 0,  115};
    tbl[2] = '{"stall",     0, 4, 5, 0,  120};
    tbl[3] = '{"restart",   2, 0, 0, 50, 115};
    tbl[4] = '{"alt",       3, 0, 0, 0,  115};

    host_if.word_in    = '0;
    host_if.word_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", "prgm_b", int'(prgm_b), 1);
    check("reset", "clb_prgm_b", int'(CLB_prgm_b), 0);
    check("reset", "cfg_en", int'(cfg_en), 0);
    check("reset", "bit_out", int'(bit_out), 0);
    check("reset", "busy", int'(busy), 0);
    check("reset", "done", int'(done), 0);
    check("reset", "word_ready", int'(host_if.word_ready), 0);
    reset_b = 1'b1;

    // A word offered while idle must not be taken.
    host_if.word_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_valid", "word_ready", int'(host_if.word_ready), 0);
    end
    host_if.word_valid = 1'b0;

    for (int k = 0; k < 5; k++) begin
      run_session(tbl[k].tag, tbl[k].pat, tbl[k].sw, tbl[k].sl, tbl[k].restart, tbl[k].exp_done);
    end

    for (int k = 0; k < 4; k++) begin
      int sw = $urandom_range(13, 1);
      int sl = $urandom_range(6, 0);
      run_session($sformatf("rnd%0d_w%0d_s%0d", k, sw, sl), 2, sw, sl, 0, -1);
    end

    // Reset asserted in the middle of a session.
    make_words(2);
    host_stop = 1'b0;
    @(posedge clk);
    #1;
    t0    = edges;
    start = 1'b1;
    fork
      host_loop(0, 0);
      begin
        @(posedge clk);
        #1;
        start = 1'b0;
        while ((edges - t0) < 60) begin
          @(posedge clk);
          #1;
        end
        check("midrst", "busy_before", int'(busy), 1);
        check("midrst", "cfg_en_before", int'(cfg_en), 1);
        reset_b = 1'b0;
        #1;
        check("midrst", "prgm_b", int'(prgm_b), 1);
        check("midrst", "clb_prgm_b", int'(CLB_prgm_b), 0);
        check("midrst", "cfg_en", int'(cfg_en), 0);
        check("midrst", "busy", int'(busy), 0);
        check("midrst", "word_ready", int'(host_if.word_ready), 0);
        check("midrst", "bit_out", int'(bit_out), 0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst", "prgm_b_held", int'(prgm_b), 1);
        check("midrst", "busy_held", int'(busy), 0);
        reset_b   = 1'b1;
        host_stop = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    run_session("post_reset", 0, 0, 0, 0, 115);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
